// File: rtl/bridge_timers_pkg.sv
// Shared constants and decode helper for the CPU-to-peripheral timer bridge.
package bridge_timers_pkg;

    // Channel register offsets (addr[3:2])
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PRESET  = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;

    // Interrupt unit register offsets
    localparam logic [1:0] REG_IPEND   = 2'd0;
    localparam logic [1:0] REG_IMASK   = 2'd1;

    // MODE encodings: only auto-reload is special, 00 and 1x are one-shot
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    // Slot addr[7:4] that selects the interrupt unit
    localparam logic [3:0] INTC_SLOT   = 4'hF;

    // Lowest HWInt bit driven by channel 0
    localparam int         HWINT_BASE  = 2;

    typedef struct packed {
        logic       hit;
        logic [3:0] ch;
        logic [1:0] roff;
    } dec_t;

    // Split the decoded part of the byte address into window hit, slot and register
    function automatic dec_t decode(input logic [15:2] a, input logic [7:0] base_hi);
        dec_t d;
        d.hit  = (a[15:8] == base_hi);
        d.ch   = a[7:4];
        d.roff = a[3:2];
        return d;
    endfunction

endpackage

// File: rtl/bridge_timers_timer_ch.sv
// One down-counting timer channel: CTRL/PRESET/COUNT registers and a 1-cycle event pulse.
module timer_ch
    import bridge_timers_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  roff,
    input  logic        we_sel,
    input  logic [31:0] dataI,
    output logic [31:0] rdata,
    output logic        evt
);

    logic        en;
    logic [1:0]  mode;
    logic [31:0] preset;
    logic [31:0] count;
    logic        wr_preset;
    logic        wr_ctrl;

    assign wr_preset = we_sel && (roff == REG_PRESET);
    assign wr_ctrl   = we_sel && (roff == REG_CTRL);

    // A CPU write to PRESET or CTRL pre-empts counting, so it also suppresses the event
    assign evt = en && (count == 32'd1) && !wr_preset && !wr_ctrl;

    // Register writes take priority over counting; COUNT==0 holds so PRESET=0 is inert
    always_ff @(posedge clk) begin
        if (reset) begin
            en     <= 1'b0;
            mode   <= 2'b00;
            preset <= '0;
            count  <= '0;
        end else if (wr_preset) begin
            preset <= dataI;
            count  <= dataI;
        end else if (wr_ctrl) begin
            en     <= dataI[0];
            mode   <= dataI[2:1];
        end else if (en) begin
            if (count > 32'd1) begin
                count <= count - 32'd1;
            end else if (count == 32'd1) begin
                if (mode == MODE_RELOAD) begin
                    count <= preset;
                end else begin
                    count <= '0;
                    en    <= 1'b0;
                end
            end
        end
    end

    // Register read mux; offset 3 is reserved
    always_comb begin
        rdata = '0;
        case (roff)
            REG_CTRL:   rdata = {29'd0, mode, en};
            REG_PRESET: rdata = preset;
            REG_COUNT:  rdata = count;
            default:    rdata = '0;
        endcase
    end

endmodule

// File: rtl/bridge_timers.sv
// Bridge top: I/O window decode, per-channel timers, read mux and the interrupt unit.
module bridge_timers
    import bridge_timers_pkg::*;
#(
    parameter int         NUM_TIMERS = 2,
    parameter logic [7:0] BASE_HI    = 8'h7f
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] dataI,
    input  logic        we,
    output logic [31:0] dataO,
    output logic [7:2]  HWInt
);

    dec_t                             dec;
    logic [NUM_TIMERS-1:0][31:0]      ch_rdata;
    logic [NUM_TIMERS-1:0]            ch_we;
    logic [NUM_TIMERS-1:0]            evt;
    logic [NUM_TIMERS-1:0]            ipend;
    logic [NUM_TIMERS-1:0]            imask;
    logic                             intc_we;
    logic                             unused_addr;

    assign dec         = decode(addr[15:2], BASE_HI);
    assign intc_we     = we && dec.hit && (dec.ch == INTC_SLOT);
    assign unused_addr = ^{addr[31:16], addr[1:0]};

    genvar i;
    generate
        for (i = 0; i < NUM_TIMERS; i++) begin : g_ch
            assign ch_we[i] = we && dec.hit && (dec.ch == 4'(i));
            timer_ch u_ch (
                .clk    (clk),
                .reset  (reset),
                .roff   (dec.roff),
                .we_sel (ch_we[i]),
                .dataI  (dataI),
                .rdata  (ch_rdata[i]),
                .evt    (evt[i])
            );
        end
    endgenerate

    // Sticky pending bits: events OR in after the W1C, so a same-cycle event wins
    always_ff @(posedge clk) begin
        if (reset) begin
            ipend <= '0;
            imask <= '1;
        end else begin
            if (intc_we && (dec.roff == REG_IPEND))
                ipend <= (ipend & ~dataI[NUM_TIMERS-1:0]) | evt;
            else
                ipend <= ipend | evt;
            if (intc_we && (dec.roff == REG_IMASK))
                imask <= dataI[NUM_TIMERS-1:0];
        end
    end

    // Read mux: unmapped slots and misses read zero
    always_comb begin
        dataO = '0;
        if (dec.hit) begin
            if (dec.ch == INTC_SLOT) begin
                if (dec.roff == REG_IPEND)
                    dataO[NUM_TIMERS-1:0] = ipend;
                else if (dec.roff == REG_IMASK)
                    dataO[NUM_TIMERS-1:0] = imask;
            end else begin
                for (int k = 0; k < NUM_TIMERS; k++)
                    if (dec.ch == 4'(k))
                        dataO = ch_rdata[k];
            end
        end
    end

    // Mask gates only the output lines; upper lines beyond NUM_TIMERS stay 0
    always_comb begin
        HWInt = '0;
        HWInt[HWINT_BASE +: NUM_TIMERS] = ipend & imask;
    end

endmodule

// File: tb/tb_bridge_timers.sv
// Self-checking bench: directed scenarios then random traffic against a behavioural model.
module tb_bridge_timers;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] dataI;
    logic        we;
    logic [31:0] dataO;
    logic [7:2]  HWInt;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic        m_en     [N];
    logic [1:0]  m_mode   [N];
    logic [31:0] m_preset [N];
    logic [31:0] m_count  [N];
    logic [N-1:0] m_ipend;
    logic [N-1:0] m_imask;

    bridge_timers #(.NUM_TIMERS(N), .BASE_HI(8'h7f)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .dataI (dataI),
        .we    (we),
        .dataO (dataO),
        .HWInt (HWInt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mread(input logic [31:0] a);
        int c;
        int r;
        c = int'(a[7:4]);
        r = int'(a[3:2]);
        if (a[15:8] != 8'h7f) return 32'd0;
        if (c == 15) begin
            if (r == 0) return 32'(m_ipend);
            if (r == 1) return 32'(m_imask);
            return 32'd0;
        end
        if (c < N) begin
            if (r == 0) return {29'd0, m_mode[c], m_en[c]};
            if (r == 1) return m_preset[c];
            if (r == 2) return m_count[c];
        end
        return 32'd0;
    endfunction

    function automatic logic [5:0] mhw();
        logic [5:0] h;
        h = '0;
        h[N-1:0] = m_ipend & m_imask;
        return h;
    endfunction

    // Apply one clock of the spec's per-channel rules to the model
    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        logic [N-1:0] ev;
        logic hit;
        int c;
        int o;
        ev  = '0;
        hit = (a[15:8] == 8'h7f);
        c   = int'(a[7:4]);
        o   = int'(a[3:2]);
        for (int i = 0; i < N; i++) begin
            if (r) begin
                m_en[i] = 1'b0; m_mode[i] = 2'b00; m_preset[i] = 32'd0; m_count[i] = 32'd0;
            end else if (w && hit && c == i && o == 1) begin
                m_preset[i] = d; m_count[i] = d;
            end else if (w && hit && c == i && o == 0) begin
                m_en[i] = d[0]; m_mode[i] = d[2:1];
            end else if (m_en[i]) begin
                if (m_count[i] > 32'd1) begin
                    m_count[i] = m_count[i] - 32'd1;
                end else if (m_count[i] == 32'd1) begin
                    ev[i] = 1'b1;
                    if (m_mode[i] == 2'b01) m_count[i] = m_preset[i];
                    else begin m_count[i] = 32'd0; m_en[i] = 1'b0; end
                end
            end
        end
        if (r) begin
            m_ipend = '0;
            m_imask = '1;
        end else begin
            if (w && hit && c == 15 && o == 0) m_ipend = m_ipend & ~d[N-1:0];
            m_ipend = m_ipend | ev;
            if (w && hit && c == 15 && o == 1) m_imask = d[N-1:0];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drive at negedge, model updates on the active edge, sample at the next negedge
    task automatic tick(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r,
                        input string tag);
        addr = a; dataI = d; we = w; reset = r;
        @(posedge clk);
        model_step(a, d, w, r);
        @(negedge clk);
        we = 1'b0; reset = 1'b0;
        chk({tag, "/dataO"}, dataO, mread(addr));
        chk({tag, "/HWInt"}, 32'(HWInt), 32'(mhw()));
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        addr = a; we = 1'b0;
        #1;
        chk(tag, dataO, mread(a));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [7:0]  hi;
        logic [3:0]  ch;
        logic [1:0]  off;
        int          sel;

        addr = 32'd0; dataI = 32'd0; we = 1'b0; reset = 1'b1;
        @(negedge clk);
        tick(32'h0, 32'h0, 1'b0, 1'b1, "rst");
        tick(32'h0, 32'h0, 1'b0, 1'b1, "rst");

        // 1. reset state
        rd(32'h7f00, "r_ctrl");  chk("r_ctrl_lit",  dataO, 32'd0);
        rd(32'h7f04, "r_pre");   chk("r_pre_lit",   dataO, 32'd0);
        rd(32'h7f08, "r_cnt");   chk("r_cnt_lit",   dataO, 32'd0);
        rd(32'h7ff0, "r_ipend"); chk("r_ipend_lit", dataO, 32'd0);
        rd(32'h7ff4, "r_imask"); chk("r_imask_lit", dataO, 32'h3);
        chk("r_hwint_lit", 32'(HWInt), 32'd0);

        // 2. one-shot on ch0
        tick(32'h7f04, 32'd5, 1'b1, 1'b0, "os_pre");
        tick(32'h7f00, 32'd1, 1'b1, 1'b0, "os_ctrl");
        rd(32'h7f08, "os_cnt0"); chk("os_cnt0_lit", dataO, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) chk("os_hw_before", 32'(HWInt[2]), 32'd0);
            tick(32'h7f08, 32'd0, 1'b0, 1'b0, "os_run");
            chk("os_cnt_lit", dataO, 32'(5 - k));
        end
        chk("os_hw_after", 32'(HWInt[2]), 32'd1);
        rd(32'h7ff0, "os_ipend"); chk("os_ipend_lit", dataO & 32'h1, 32'h1);
        rd(32'h7f00, "os_ctrl_rd"); chk("os_ctrl_lit", dataO, 32'd0);
        tick(32'h7ff0, 32'h3, 1'b1, 1'b0, "os_clr");

        // 3. auto-reload on ch1, period 3
        tick(32'h7f14, 32'd3, 1'b1, 1'b0, "ar_pre");
        tick(32'h7f10, 32'd3, 1'b1, 1'b0, "ar_ctrl");
        rd(32'h7f18, "ar_cnt0");
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick(32'h7f18, 32'd0, 1'b0, 1'b0, "ar_run");
            chk("ar_cnt_lit", dataO, 32'(3 - (k % 3)));
        end
        chk("ar_hw3", 32'(HWInt[3]), 32'd1);

        // 4. W1C colliding with a ch0 reload event
        tick(32'h7f04, 32'd4, 1'b1, 1'b0, "wc_pre");
        tick(32'h7f00, 32'd3, 1'b1, 1'b0, "wc_ctrl");
        for (int g = 0; g < 20 && m_count[0] != 32'd1; g++)
            tick(32'h7f08, 32'd0, 1'b0, 1'b0, "wc_wait");
        rd(32'h7f08, "wc_cnt"); chk("wc_cnt_lit", dataO, 32'd1);
        tick(32'h7ff0, 32'h1, 1'b1, 1'b0, "wc_col");
        chk("wc_setwins", dataO & 32'h1, 32'h1);
        tick(32'h7ff0, 32'h1, 1'b1, 1'b0, "wc_quiet");
        chk("wc_cleared", dataO & 32'h1, 32'h0);
        chk("wc_hw2_low", 32'(HWInt[2]), 32'd0);

        // 5. masked event latches, unmask exposes it
        tick(32'h7ff4, 32'h0, 1'b1, 1'b0, "mk_off");
        for (int g = 0; g < 20 && !m_ipend[0]; g++)
            tick(32'h7f08, 32'd0, 1'b0, 1'b0, "mk_wait");
        rd(32'h7ff0, "mk_ipend"); chk("mk_ipend_lit", dataO & 32'h1, 32'h1);
        chk("mk_hw_lit", 32'(HWInt), 32'd0);
        tick(32'h7ff4, 32'h1, 1'b1, 1'b0, "mk_on");
        chk("mk_hw2_lit", 32'(HWInt[2]), 32'd1);

        // 6. unmapped accesses and reset mid-count
        rd(32'h7f20, "um_rd0"); chk("um_rd0_lit", dataO, 32'd0);
        rd(32'h7ff8, "um_rd1"); chk("um_rd1_lit", dataO, 32'd0);
        rd(32'h7e00, "um_rd2"); chk("um_rd2_lit", dataO, 32'd0);
        tick(32'h7f24, 32'hdead_beef, 1'b1, 1'b0, "um_w0");
        tick(32'h7ffc, 32'hffff_ffff, 1'b1, 1'b0, "um_w1");
        tick(32'h7e04, 32'h0000_0077, 1'b1, 1'b0, "um_w2");
        tick(32'h7f0c, 32'h0000_0077, 1'b1, 1'b0, "um_w3");
        rd(32'h7f04, "um_pre0"); chk("um_pre0_lit", dataO, 32'd4);
        rd(32'h7f14, "um_pre1"); chk("um_pre1_lit", dataO, 32'd3);
        rd(32'h7ff4, "um_imask");
        for (int g = 0; g < 20 && m_count[0] != 32'd2; g++)
            tick(32'h7f08, 32'd0, 1'b0, 1'b0, "mr_wait");
        rd(32'h7f08, "mr_cnt"); chk("mr_cnt_lit", dataO, 32'd2);
        tick(32'h7f08, 32'd0, 1'b0, 1'b1, "mr_rst");
        chk("mr_hw_lit", 32'(HWInt), 32'd0);
        rd(32'h7f00, "mr_ctrl0"); chk("mr_ctrl0_lit", dataO, 32'd0);
        rd(32'h7f04, "mr_pre0");  chk("mr_pre0_lit",  dataO, 32'd0);
        rd(32'h7f08, "mr_cnt0");  chk("mr_cnt0_lit",  dataO, 32'd0);
        rd(32'h7f18, "mr_cnt1");  chk("mr_cnt1_lit",  dataO, 32'd0);
        rd(32'h7ff0, "mr_ipend"); chk("mr_ipend_lit", dataO, 32'd0);
        rd(32'h7ff4, "mr_imask"); chk("mr_imask_lit", dataO, 32'h3);
        tick(32'h7ff0, 32'd0, 1'b0, 1'b0, "mr_quiet");
        chk("mr_noevt", dataO, 32'd0);

        // 7. random traffic against the model
        for (int n = 0; n < 600; n++) begin
            hi  = ($urandom_range(0, 15) == 0) ? 8'h7e : 8'h7f;
            sel = $urandom_range(0, 5);
            ch  = (sel <= 1) ? 4'd0 : (sel <= 3) ? 4'd1 : (sel == 4) ? 4'hf : 4'($urandom_range(0, 15));
            off = 2'($urandom_range(0, 3));
            a   = {16'($urandom), hi, ch, off, 2'($urandom_range(0, 3))};
            d   = (off == 2'd1 && ch < 4'd2) ? 32'($urandom_range(0, 6)) : 32'($urandom);
            tick(a, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
